// File: rtl/uart_tx_frame_pkg.sv
// Shared types and constants for the UART transmit framer.
// Holds the FSM encoding, parity selector values and default line levels.
package uart_tx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic DEF_START_BIT = 1'b0;
    localparam logic DEF_STOP_BIT  = 1'b1;

    // Parity bit from the XOR-reduction of the payload and the parity type
    function automatic logic parity_bit(input logic xor_bits, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~xor_bits : xor_bits;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART transmit framer.
// serial_o presents the next bit to put on the line; done_o flags the last data bit.
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  shift_i,
    output logic                  serial_o,
    output logic                  done_o
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Counter is preset to the last index so the first shift (entering DATA) wraps it to 0;
    // from then on it holds the index of the bit currently on the line.
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            sreg_d = data_i;
            cnt_d  = LAST_IDX;
        end else if (shift_i) begin
            sreg_d = sreg_q >> 1;
            cnt_d  = (cnt_q == LAST_IDX) ? '0 : CNT_W'(cnt_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign serial_o = sreg_q[0];
    assign done_o   = (cnt_q == LAST_IDX);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first payload, optional parity, stop bit.
// One line bit per CLK_DESERIALIZER edge; TX_OUT and BUSY come straight from flops.
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic        START_BIT  = DEF_START_BIT,
    parameter logic        STOP_BIT   = DEF_STOP_BIT
) (
    input  logic                  CLK_DESERIALIZER,
    input  logic                  RST_DESERIALIZER,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    tx_state_e state_q, state_d;
    logic      tx_q, tx_d;
    logic      busy_q, busy_d;
    logic      par_en_q, par_en_d;
    logic      parity_q, parity_d;
    logic      accept;
    logic      ser_load, ser_shift, ser_bit, ser_done;

    assign accept = (state_q == ST_IDLE) && DATA_VALID;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk_i    (CLK_DESERIALIZER),
        .rst_ni   (RST_DESERIALIZER),
        .load_i   (ser_load),
        .data_i   (P_DATA),
        .shift_i  (ser_shift),
        .serial_o (ser_bit),
        .done_o   (ser_done)
    );

    always_ff @(posedge CLK_DESERIALIZER or negedge RST_DESERIALIZER) begin
        if (!RST_DESERIALIZER) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (DATA_VALID) state_d = ST_START;
            ST_START:  state_d = ST_DATA;
            ST_DATA:   if (ser_done) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Line level and busy flag for the upcoming cycle, plus serializer control
    always_comb begin
        tx_d      = STOP_BIT;
        busy_d    = 1'b0;
        ser_load  = accept;
        ser_shift = 1'b0;
        unique case (state_d)
            ST_IDLE:   tx_d = STOP_BIT;
            ST_START:  tx_d = START_BIT;
            ST_DATA:   tx_d = ser_bit;
            ST_PARITY: tx_d = parity_q;
            ST_STOP:   tx_d = STOP_BIT;
            default:   tx_d = STOP_BIT;
        endcase
        busy_d = (state_d != ST_IDLE);
        if ((state_q == ST_START) || ((state_q == ST_DATA) && !ser_done)) begin
            ser_shift = 1'b1;
        end
    end

    // Frame settings are captured only on the accepting edge
    always_comb begin
        par_en_d = par_en_q;
        parity_d = parity_q;
        if (accept) begin
            par_en_d = PAR_EN;
            parity_d = parity_bit(^P_DATA, PAR_TYP);
        end
    end

    always_ff @(posedge CLK_DESERIALIZER or negedge RST_DESERIALIZER) begin
        if (!RST_DESERIALIZER) begin
            tx_q     <= STOP_BIT;
            busy_q   <= 1'b0;
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            par_en_q <= par_en_d;
            parity_q <= parity_d;
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed and table-driven bench for uart_tx_frame (DATA_WIDTH = 8).
// Line frames are written cycle 0 first in the MSB of an 11-bit field.
module tb_uart_tx_frame;
    import uart_tx_frame_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  data;
        logic        pen;
        logic        ptyp;
        logic [10:0] line;
        int          len;
    } vec_t;

    vec_t vecs[8];

    uart_tx_frame #(
        .DATA_WIDTH (8),
        .START_BIT  (1'b0),
        .STOP_BIT   (1'b1)
    ) dut (
        .CLK_DESERIALIZER (clk),
        .RST_DESERIALIZER (rst_n),
        .P_DATA           (p_data),
        .DATA_VALID       (data_valid),
        .PAR_EN           (par_en),
        .PAR_TYP          (par_typ),
        .TX_OUT           (tx_out),
        .BUSY             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic logic [10:0] model_line(input logic [7:0] d, input logic pen, input logic ptyp);
        logic [10:0] l;
        l     = '0;
        l[10] = 1'b0;
        for (int i = 0; i < 8; i++) l[9-i] = d[i];
        if (pen) begin
            l[1] = (^d) ^ ptyp;
            l[0] = 1'b1;
        end else begin
            l[1] = 1'b1;
            l[0] = 1'b0;
        end
        return l;
    endfunction

    // Called at a negedge with the line idle; returns at the negedge of the first idle cycle.
    // inj >= 0 pulses DATA_VALID with 0xFF during frame cycle index inj.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pen,
                             input logic ptyp, input logic [10:0] line, input int len,
                             input int inj);
        check($sformatf("%s idle_tx", tag), tx_out, 1'b1);
        check($sformatf("%s idle_busy", tag), busy, 1'b0);
        p_data     = d;
        par_en     = pen;
        par_typ    = ptyp;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        p_data     = ~d;
        par_en     = ~pen;
        par_typ    = ~ptyp;
        for (int c = 0; c < len; c++) begin
            check($sformatf("%s c%0d tx", tag, c), tx_out, line[10-c]);
            check($sformatf("%s c%0d busy", tag, c), busy, 1'b1);
            if (c == inj) begin
                data_valid = 1'b1;
                p_data     = 8'hFF;
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s i%0d tx", tag, i), tx_out, 1'b1);
            check($sformatf("%s i%0d busy", tag, i), busy, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0]  rd;
        logic        rpen;
        logic        rptyp;
        logic [10:0] l81;

        vecs[0] = '{8'hA5, 1'b0, PAR_EVEN, 11'b01010010110, 10};
        vecs[1] = '{8'hA5, 1'b1, PAR_EVEN, 11'b01010010101, 11};
        vecs[2] = '{8'hA5, 1'b1, PAR_ODD,  11'b01010010111, 11};
        vecs[3] = '{8'h00, 1'b0, PAR_EVEN, 11'b00000000010, 10};
        vecs[4] = '{8'hFF, 1'b1, PAR_EVEN, 11'b01111111101, 11};
        vecs[5] = '{8'h3C, 1'b1, PAR_ODD,  11'b00011110011, 11};
        vecs[6] = '{8'h81, 1'b1, PAR_EVEN, 11'b01000000101, 11};
        vecs[7] = '{8'h01, 1'b1, PAR_ODD,  11'b01000000001, 11};

        rst_n      = 1'b1;
        p_data     = '0;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        #1 rst_n   = 1'b0;
        #2;
        check("reset tx", tx_out, 1'b1);
        check("reset busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back table frames: each starts on the first idle cycle
        for (int v = 0; v < 8; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].pen, vecs[v].ptyp,
                      vecs[v].line, vecs[v].len, -1);
        end

        // Request during frame cycle 4 is dropped and does not touch the 0x3C payload
        run_frame("drop3C", 8'h3C, 1'b0, PAR_EVEN, 11'b00011110010, 10, 3);
        check_idle("drop_idle", 12);

        // Asynchronous reset in cycle 5 of a 0x81 frame
        l81 = 11'b01000000101;
        check("rst81 idle_tx", tx_out, 1'b1);
        p_data     = 8'h81;
        par_en     = 1'b1;
        par_typ    = PAR_EVEN;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("rst81 c%0d tx", c), tx_out, l81[10-c]);
            check($sformatf("rst81 c%0d busy", c), busy, 1'b1);
            if (c < 4) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst81 async tx", tx_out, 1'b1);
        check("rst81 async busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("rst81_after", 15);
        run_frame("post_rst", vecs[0].data, vecs[0].pen, vecs[0].ptyp,
                  vecs[0].line, vecs[0].len, -1);

        // Random payloads against the line model
        for (int r = 0; r < 30; r++) begin
            rd    = 8'($urandom_range(0, 255));
            rpen  = 1'($urandom_range(0, 1));
            rptyp = 1'($urandom_range(0, 1));
            run_frame($sformatf("rnd%0d", r), rd, rpen, rptyp,
                      model_line(rd, rpen, rptyp), rpen ? 11 : 10, -1);
        end
        check_idle("final", 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
